decoder3_8_seq: RTL and testbench

Registered 3-to-8 one-hot decoder that performs the inverse of the team's 8-to-3 encoder. It turns a 3-bit code into a held one-hot select line using a valid/ready handshake. It also provides a self-timed scan mode that walks all 8 outputs in order, each held for a programmable dwell time. The block drives downstream select/enable lines (LED banks, mux selects, chip selects).

---
 rtl/decoder_pkg.sv | 15 +
 rtl/decoder3_8_seq_dwell_counter.sv | 25 ++
 rtl/decoder3_8_seq.sv | 128 ++++++++++++
 tb/tb_decoder3_8_seq.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared types and helpers for the registered 3-to-8 decoder.
package decoder_pkg;
   localparam int CODE_W  = 3;
   localparam int NUM_OUT = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      SCAN = 2'd2
   } state_t;

   function automatic logic [NUM_OUT-1:0] onehot8(input logic [CODE_W-1:0] code);
      return 8'h01 << code;
   endfunction
endpackage

// File: rtl/decoder3_8_seq_dwell_counter.sv
// Loadable down-counter used to time each scan step.
module dwell_counter #(
   parameter int DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               load,
   input  logic [DWELL_W-1:0] load_val,
   input  logic               dec,
   output logic               zero
);
   logic [DWELL_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clr)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (dec && cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign zero = (cnt == '0);
endmodule

// File: rtl/decoder3_8_seq.sv
// Registered 3-to-8 one-hot decoder with valid/ready input and a self-timed scan mode.
module decoder3_8_seq
   import decoder_pkg::*;
#(
   parameter int DWELL_W    = 8,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [2:0]         din,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               scan_start,
   input  logic [DWELL_W-1:0] dwell,
   output logic [7:0]         dout,
   output logic               dout_valid,
   output logic               busy,
   output logic               scan_done
);
   state_t               state;
   logic [CODE_W-1:0]    idx;
   logic [DWELL_W-1:0]   dwell_q;
   logic [NUM_OUT-1:0]   dout_l;

   logic                 cnt_clr;
   logic                 cnt_load;
   logic                 cnt_dec;
   logic [DWELL_W-1:0]   cnt_val;
   logic                 cnt_zero;

   logic                 accept_scan;
   logic                 accept_dec;

   assign in_ready    = en && !busy && !rst;
   assign accept_scan = in_ready && scan_start;
   assign accept_dec  = in_ready && in_valid && !scan_start;

   // First step loads the live dwell input; later steps reload the captured copy.
   always_comb begin
      cnt_clr  = !en;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      cnt_val  = dwell_q;
      if (en) begin
         if (accept_scan) begin
            cnt_load = 1'b1;
            cnt_val  = dwell;
         end else if (state == SCAN) begin
            if (!cnt_zero)
               cnt_dec = 1'b1;
            else if (idx != CODE_W'(NUM_OUT - 1))
               cnt_load = 1'b1;
         end
      end
   end

   dwell_counter #(.DWELL_W(DWELL_W)) u_dwell (
      .clk      (clk),
      .rst      (rst),
      .clr      (cnt_clr),
      .load     (cnt_load),
      .load_val (cnt_val),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         idx        <= '0;
         dwell_q    <= '0;
         dout_l     <= '0;
         dout_valid <= 1'b0;
         busy       <= 1'b0;
         scan_done  <= 1'b0;
      end else begin
         scan_done <= 1'b0;
         if (!en) begin
            state      <= IDLE;
            idx        <= '0;
            dout_l     <= '0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
         end else begin
            case (state)
               IDLE, HOLD: begin
                  if (accept_scan) begin
                     state      <= SCAN;
                     idx        <= '0;
                     dwell_q    <= dwell;
                     dout_l     <= onehot8('0);
                     dout_valid <= 1'b1;
                     busy       <= 1'b1;
                  end else if (accept_dec) begin
                     state      <= HOLD;
                     dout_l     <= onehot8(din);
                     dout_valid <= 1'b1;
                  end
               end
               SCAN: begin
                  if (cnt_zero) begin
                     if (idx != CODE_W'(NUM_OUT - 1)) begin
                        idx    <= idx + 1'b1;
                        dout_l <= onehot8(idx + 1'b1);
                     end else begin
                        state      <= IDLE;
                        idx        <= '0;
                        dout_l     <= '0;
                        dout_valid <= 1'b0;
                        busy       <= 1'b0;
                        scan_done  <= 1'b1;
                     end
                  end
               end
               default: begin
                  state      <= IDLE;
                  dout_l     <= '0;
                  dout_valid <= 1'b0;
                  busy       <= 1'b0;
               end
            endcase
         end
      end
   end

   assign dout = ACTIVE_LOW ? ~dout_l : dout_l;
endmodule

// File: tb/tb_decoder3_8_seq.sv
// Directed bench for decoder3_8_seq: a schedule-based model checked every cycle plus literal spot checks.
module tb_decoder3_8_seq;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b1;
   logic [2:0] din = '0;
   logic       in_valid = 1'b0;
   logic       scan_start = 1'b0;
   logic [7:0] dwell = '0;

   logic [7:0] dout, dout_n;
   logic       dout_valid, in_ready, busy, scan_done;
   logic       b_valid, b_ready, b_busy, b_done;

   int errors = 0;
   int checks = 0;

   decoder3_8_seq #(.DWELL_W(8), .ACTIVE_LOW(1'b0)) dut (
      .clk(clk), .rst(rst), .en(en), .din(din), .in_valid(in_valid), .in_ready(in_ready),
      .scan_start(scan_start), .dwell(dwell), .dout(dout), .dout_valid(dout_valid),
      .busy(busy), .scan_done(scan_done)
   );

   decoder3_8_seq #(.DWELL_W(8), .ACTIVE_LOW(1'b1)) dut_n (
      .clk(clk), .rst(rst), .en(en), .din(din), .in_valid(in_valid), .in_ready(b_ready),
      .scan_start(scan_start), .dwell(dwell), .dout(dout_n), .dout_valid(b_valid),
      .busy(b_busy), .scan_done(b_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a scan is a precomputed list of per-cycle output codes.
   logic [7:0] q[$];
   logic [7:0] m_dout;
   logic       m_valid, m_busy, m_done, armed = 1'b0;

   always @(posedge clk) begin
      m_done = 1'b0;
      if (rst || !en) begin
         if (rst) armed = 1'b1;
         q.delete();
         m_dout = 8'h00; m_valid = 1'b0; m_busy = 1'b0;
      end else if (m_busy) begin
         if (q.size() > 0) begin
            m_dout = q.pop_front();
         end else begin
            m_dout = 8'h00; m_valid = 1'b0; m_busy = 1'b0; m_done = 1'b1;
         end
      end else if (scan_start) begin
         for (int k = 0; k < 8; k++)
            for (int r = 0; r <= int'(dwell); r++)
               q.push_back(8'(1 << k));
         m_dout = q.pop_front(); m_valid = 1'b1; m_busy = 1'b1;
      end else if (in_valid) begin
         m_dout = 8'(1 << din); m_valid = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         chk("dout", dout, m_dout);
         chk("dout_n", dout_n, ~m_dout);
         chk("dout_valid", {7'd0, dout_valid}, {7'd0, m_valid});
         chk("busy", {7'd0, busy}, {7'd0, m_busy});
         chk("scan_done", {7'd0, scan_done}, {7'd0, m_done});
         chk("in_ready", {7'd0, in_ready}, {7'd0, en && !m_busy && !rst});
         chk("b_ctrl", {4'd0, b_valid, b_ready, b_busy, b_done},
             {4'd0, dout_valid, in_ready, busy, scan_done});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int n;

   initial begin
      // reset
      step(); step();
      chk("rst_dout", dout, 8'h00);
      chk("rst_dout_n", dout_n, 8'hFF);
      chk("rst_flags", {5'd0, dout_valid, busy, scan_done}, 8'h00);
      rst = 1'b0;

      // decode sweep
      in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         din = 3'(i);
         step();
         chk("sweep", dout, 8'(1 << i));
      end
      in_valid = 1'b0;
      step(); step(); step();
      chk("hold_80", dout, 8'h80);
      chk("hold_valid", {7'd0, dout_valid}, 8'h01);

      // scan dwell=2, with simultaneous decode request that must lose
      dwell = 8'd2; scan_start = 1'b1; in_valid = 1'b1; din = 3'd5;
      step();
      scan_start = 1'b0; in_valid = 1'b0;
      chk("prio_01", dout, 8'h01);
      dwell = 8'd9;
      n = 0;
      while (!scan_done && n < 100) begin
         if (dout != 8'h00) n++;
         if (n == 5) scan_start = 1'b1;
         if (n == 6) scan_start = 1'b0;
         step();
      end
      scan_start = 1'b0;
      chk("scan_len", 8'(n), 8'd24);
      chk("scan_end_dout", dout, 8'h00);
      chk("scan_end_done", {7'd0, scan_done}, 8'h01);
      step();
      chk("done_pulse", {7'd0, scan_done}, 8'h00);

      // abort at 08 with dwell=0
      dwell = 8'd0; scan_start = 1'b1;
      step();
      scan_start = 1'b0;
      n = 0;
      while (dout != 8'h08 && n < 20) begin n++; step(); end
      chk("abort_reach", dout, 8'h08);
      en = 1'b0;
      step();
      chk("abort_dout", dout, 8'h00);
      chk("abort_flags", {6'd0, busy, scan_done}, 8'h00);
      en = 1'b1; in_valid = 1'b1; din = 3'd3;
      step();
      in_valid = 1'b0;
      chk("redecode", dout, 8'h08);

      // reset mid-scan at 10
      dwell = 8'd1; scan_start = 1'b1;
      step();
      scan_start = 1'b0;
      n = 0;
      while (dout != 8'h10 && n < 40) begin n++; step(); end
      chk("rst_reach", dout, 8'h10);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_dout", dout, 8'h00);
      chk("midrst_flags", {5'd0, dout_valid, busy, scan_done}, 8'h00);
      step(); step();
      chk("post_rst_done", {7'd0, scan_done}, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
